// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: o_Tick marks the final cycle of each CLKS_PER_BIT period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            cnt <= '0;
        end else if (i_Clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_Tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter launched on a rising edge of i_Transmit; registered outputs.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Transmit,
    input  logic [DATA_BITS-1:0] i_Data,
    output logic                 o_Tx,
    output logic                 o_Busy,
    output logic                 o_Done
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 prev;
    logic                 launch, tick, clear;
    logic                 tx_next, busy_next, done_next;

    assign launch = i_Transmit & ~prev;
    assign clear  = (state_next != state);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Clear (clear),
        .o_Tick  (tick)
    );

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (launch) begin
                    shift_next   = i_Data;
                    bit_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        tx_next   = 1'b1;
        busy_next = 1'b1;
        case (state_next)
            IDLE:    busy_next = 1'b0;
            START:   tx_next   = 1'b0;
            DATA:    tx_next   = shift_next[0];
            default: ;
        endcase
    end

    // NOTE: the shift register is reset along with everything else; it is a
    // single small register, not a memory array, so the reset costs nothing.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            prev    <= 1'b1;
            o_Tx    <= 1'b1;
            o_Busy  <= 1'b0;
            o_Done  <= 1'b0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            prev    <= i_Transmit;
            o_Tx    <= tx_next;
            o_Busy  <= busy_next;
            o_Done  <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4 and 8 data bits.
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       transmit;
    logic [7:0] data;
    logic       tx, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Transmit (transmit),
        .i_Data     (data),
        .o_Tx       (tx),
        .o_Busy     (busy),
        .o_Done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks a full frame cycle by cycle, starting with the launch edge already set up.
    // Optionally drops i_Transmit at cycle drop_at and raises it (with new data) at rise_at.
    task automatic run_frame(input string tag, input logic [7:0] byte_v,
                             input int drop_at, input int rise_at, input logic [7:0] rise_data);
        logic [9:0] frame;
        int         dones;
        logic       exp_tx;
        frame = {1'b1, byte_v, 1'b0};
        dones = 0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            step();
            exp_tx = (k <= FRAME) ? frame[(k - 1) / CPB] : 1'b1;
            check($sformatf("%s tx c%0d", tag, k), 32'(tx), 32'(exp_tx));
            check($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'(k <= FRAME));
            check($sformatf("%s done c%0d", tag, k), 32'(done), 32'(k == FRAME + 1));
            if (done) dones++;
            if (k == drop_at) transmit = 1'b0;
            if (k == rise_at) begin
                transmit = 1'b1;
                data     = rise_data;
            end
        end
        check({tag, " done count"}, 32'(dones), 32'd1);
    endtask

    // Runs n idle cycles and counts any activity on busy/done or a low line.
    task automatic idle_window(input string tag, input int n);
        int active;
        active = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (busy || done || !tx) active++;
        end
        check({tag, " idle activity"}, 32'(active), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        transmit = 1'b0;
        data     = 8'h00;
        repeat (3) step();
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: basic frame, A5 -> 0,1,0,1,0,0,1,0,1,1
        transmit = 1'b1;
        data     = 8'hA5;
        run_frame("basic", 8'hA5, 2, 0, 8'h00);
        idle_window("basic post", 4);

        // 2: level held high for 100 cycles gives one frame
        transmit = 1'b1;
        data     = 8'h3C;
        run_frame("level", 8'h3C, 0, 0, 8'h00);
        idle_window("level hold", 100 - (FRAME + 1));
        transmit = 1'b0;
        step();

        // 3: retrigger with FF at cycle 10 is ignored; original byte completes
        transmit = 1'b1;
        data     = 8'h96;
        run_frame("retrig", 8'h96, 5, 10, 8'hFF);
        idle_window("retrig post", 6);
        transmit = 1'b0;
        step();

        // 4: back-to-back, second launch in the done cycle with 00
        transmit = 1'b1;
        data     = 8'hC3;
        run_frame("b2b first", 8'hC3, 5, FRAME + 1, 8'h00);
        run_frame("b2b second", 8'h00, 3, 0, 8'h00);
        idle_window("b2b post", 4);

        // 5: reset asserted at cycle 15 of a frame
        transmit = 1'b1;
        data     = 8'h5A;
        for (int k = 1; k <= 14; k++) step();
        check("midrst busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        check("midrst tx", 32'(tx), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);

        // 6: i_Transmit high through reset release does not launch
        step();
        rst_n = 1'b1;
        idle_window("held rst", 20);
        transmit = 1'b0;
        step();
        transmit = 1'b1;
        data     = 8'h81;
        run_frame("held relaunch", 8'h81, 2, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
